// File: rtl/gcn_result_streamer_if.sv
// Valid/ready result stream between gcn_result_streamer and a host/DMA sink.
//   out_valid : beat valid (source)
//   out_ready : sink accepts beat (sink)
//   out_data  : {tag, idx, val} beat payload (source)
//   out_last  : final beat of a result packet (source)
interface gcn_result_streamer_if #(
  parameter int OUT_W = 7
);
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/gcn_result_streamer.sv
// Captures the GCN per-node class labels when done rises, streams them out one
// beat per node, then streams a per-class histogram of the labels sent.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   done             GCN done level; a rising edge starts a capture
//   max_addi_answer  per-node labels from the GCN core
//   out_if           valid/ready stream (master side)
//   busy             capture held / packet in progress
//   overrun          sticky: done rose while a packet was in progress
//   err_label        sticky: a label >= NUM_CLASSES was streamed
module gcn_result_streamer #(
  parameter int FEATURE_ROWS      = 6,
  parameter int MAX_ADDRESS_WIDTH = 2,
  parameter int NUM_CLASSES       = 3,
  parameter int IDX_W             = $clog2(FEATURE_ROWS),
  parameter int VAL_W             = $clog2(FEATURE_ROWS + 1),
  parameter int OUT_W             = 1 + IDX_W + VAL_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         done,
  input  logic [MAX_ADDRESS_WIDTH-1:0] max_addi_answer [0:FEATURE_ROWS-1],
  gcn_result_streamer_if.master        out_if,
  output logic                         busy,
  output logic                         overrun,
  output logic                         err_label
);

  typedef enum logic [1:0] {IDLE, LABELS, HIST} state_t;

  localparam logic [IDX_W-1:0] LAST_ROW   = IDX_W'(FEATURE_ROWS - 1);
  localparam logic [IDX_W-1:0] LAST_CLASS = IDX_W'(NUM_CLASSES - 1);
  localparam int unsigned      NC_U       = NUM_CLASSES;

  state_t                       state;
  logic                         done_q;
  logic [IDX_W-1:0]             idx;
  logic [MAX_ADDRESS_WIDTH-1:0] labels   [0:FEATURE_ROWS-1];
  logic [VAL_W-1:0]             hist     [0:NUM_CLASSES-1];
  logic [VAL_W-1:0]             hist_upd [0:NUM_CLASSES-1];

  logic                         done_rise;
  logic                         accept;
  logic [MAX_ADDRESS_WIDTH-1:0] cur_label;
  logic                         label_ok;

  assign done_rise = done & ~done_q;
  assign accept    = out_if.out_valid & out_if.out_ready;
  assign cur_label = labels[idx];
  assign label_ok  = 32'(cur_label) < NC_U;

  // Histogram including the label beat accepted on this edge, so the first
  // HIST beat can be loaded with an up-to-date count.
  always_comb begin
    hist_upd = hist;
    if (state == LABELS && accept) begin
      for (int unsigned c = 0; c < NC_U; c++) begin
        if (32'(cur_label) == c) hist_upd[c] = hist[c] + VAL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      done_q           <= 1'b0;
      idx              <= '0;
      labels           <= '{default: '0};
      hist             <= '{default: '0};
      out_if.out_valid <= 1'b0;
      out_if.out_data  <= '0;
      out_if.out_last  <= 1'b0;
      busy             <= 1'b0;
      overrun          <= 1'b0;
      err_label        <= 1'b0;
    end else begin
      done_q <= done;
      hist   <= hist_upd;
      if (done_rise && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (done_rise) begin
            labels           <= max_addi_answer;
            hist             <= '{default: '0};
            idx              <= '0;
            state            <= LABELS;
            busy             <= 1'b1;
            out_if.out_valid <= 1'b1;
            out_if.out_last  <= 1'b0;
            out_if.out_data  <= {1'b0, IDX_W'(0), VAL_W'(max_addi_answer[0])};
          end
        end

        LABELS: begin
          if (accept) begin
            if (!label_ok) err_label <= 1'b1;
            if (idx == LAST_ROW) begin
              idx             <= '0;
              state           <= HIST;
              out_if.out_data <= {1'b1, IDX_W'(0), hist_upd[0]};
              out_if.out_last <= (NC_U == 1);
            end else begin
              idx             <= idx + 1'b1;
              out_if.out_data <= {1'b0, idx + 1'b1, VAL_W'(labels[idx + 1'b1])};
            end
          end
        end

        HIST: begin
          if (accept) begin
            if (idx == LAST_CLASS) begin
              idx              <= '0;
              state            <= IDLE;
              busy             <= 1'b0;
              out_if.out_valid <= 1'b0;
              out_if.out_last  <= 1'b0;
              out_if.out_data  <= '0;
            end else begin
              idx             <= idx + 1'b1;
              out_if.out_data <= {1'b1, idx + 1'b1, hist[idx + 1'b1]};
              out_if.out_last <= ((idx + 1'b1) == LAST_CLASS);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcn_result_streamer.sv
module tb_gcn_result_streamer;
  localparam int FR    = 6;
  localparam int MAW   = 2;
  localparam int NC    = 3;
  localparam int OUT_W = 7;

  logic           clk = 1'b0;
  logic           reset;
  logic           done;
  logic [MAW-1:0] lab [0:FR-1];
  logic           busy, overrun, err_label;

  gcn_result_streamer_if #(.OUT_W(OUT_W)) sif ();

  gcn_result_streamer #(
    .FEATURE_ROWS(FR),
    .MAX_ADDRESS_WIDTH(MAW),
    .NUM_CLASSES(NC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .done(done),
    .max_addi_answer(lab),
    .out_if(sif),
    .busy(busy),
    .overrun(overrun),
    .err_label(err_label)
  );

  always #5 clk = ~clk;

  int             checks = 0;
  int             errors = 0;
  logic [OUT_W-1:0] exp_q[$];
  bit             exp_err = 1'b0;
  bit             exp_ovr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: label beats in node order, then one count per class.
  task automatic build_expected();
    int cnt;
    exp_q.delete();
    for (int i = 0; i < FR; i++) begin
      exp_q.push_back({1'b0, 3'(i), 3'(lab[i])});
      if (int'(lab[i]) >= NC) exp_err = 1'b1;
    end
    for (int c = 0; c < NC; c++) begin
      cnt = 0;
      for (int i = 0; i < FR; i++) if (int'(lab[i]) == c) cnt++;
      exp_q.push_back({1'b1, 3'(c), 3'(cnt)});
    end
  endtask

  task automatic start_packet(input bit hold);
    build_expected();
    done = 1'b1;
    @(negedge clk);
    chk("latency_valid", 32'(sif.out_valid), 1);
    chk("latency_busy", 32'(busy), 1);
    if (!hold) done = 1'b0;
  endtask

  // mode 0: ready=1, mode 1: random ready, mode 2: ready pattern 1,0,0
  task automatic stream(input int mode, input int rise_at);
    int             k = 0;
    int             cyc = 0;
    int             n;
    bit             stalled = 1'b0;
    bit             rose = 1'b0;
    bit             r;
    logic [OUT_W-1:0] pd = '0;
    logic           pl = 1'b0;
    n = exp_q.size();
    while (k < n && cyc < 300) begin
      if (stalled) begin
        chk("hold_valid", 32'(sif.out_valid), 1);
        chk("hold_data", 32'(sif.out_data), 32'(pd));
        chk("hold_last", 32'(sif.out_last), 32'(pl));
      end
      if (rise_at >= 0) begin
        if (k == rise_at && !rose) begin
          done = 1'b1;
          rose = 1'b1;
        end else if (rose) begin
          done = 1'b0;
        end
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (cyc % 3 == 0);
      endcase
      sif.out_ready = r;
      if (sif.out_valid === 1'b1 && r) begin
        chk($sformatf("beat%0d_data", k), 32'(sif.out_data), 32'(exp_q[k]));
        chk($sformatf("beat%0d_last", k), 32'(sif.out_last), 32'(k == n - 1));
        k++;
        stalled = 1'b0;
      end else if (sif.out_valid === 1'b1) begin
        stalled = 1'b1;
        pd = sif.out_data;
        pl = sif.out_last;
      end else begin
        chk("valid_drop", 32'(sif.out_valid), 1);
        stalled = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    if (rose) done = 1'b0;
    chk("packet_beats", k, n);
    if (mode == 0) chk("no_bubble_cycles", cyc, n);
    chk("end_valid", 32'(sif.out_valid), 0);
    chk("end_busy", 32'(busy), 0);
    chk("end_last", 32'(sif.out_last), 0);
    chk("err_label", 32'(err_label), 32'(exp_err));
    chk("overrun", 32'(overrun), 32'(exp_ovr));
  endtask

  initial begin
    reset = 1'b1;
    done = 1'b0;
    sif.out_ready = 1'b0;
    lab = '{default: '0};
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(sif.out_valid), 0);
    chk("rst_data", 32'(sif.out_data), 0);
    chk("rst_last", 32'(sif.out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_err", 32'(err_label), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_valid", 32'(sif.out_valid), 0);

    // T1: ready held high
    lab = '{2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2};
    start_packet(1'b0);
    stream(0, -1);

    // T2: ready toggling
    start_packet(1'b0);
    stream(2, -1);

    // T3: out-of-range label
    lab = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    start_packet(1'b0);
    stream(0, -1);

    // T4: done rises mid-packet, then a fresh packet after IDLE
    lab = '{2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2};
    start_packet(1'b0);
    exp_ovr = 1'b1;
    stream(0, 3);
    repeat (2) @(negedge clk);
    chk("t4_no_second_packet", 32'(sif.out_valid), 0);
    start_packet(1'b0);
    stream(1, -1);

    // T5: asynchronous reset while a beat is stalled
    start_packet(1'b0);
    sif.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    sif.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_stalled_data", 32'(sif.out_data), 32'(exp_q[3]));
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(sif.out_valid), 0);
    chk("t5_rst_data", 32'(sif.out_data), 0);
    chk("t5_rst_last", 32'(sif.out_last), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_overrun", 32'(overrun), 0);
    chk("t5_rst_err", 32'(err_label), 0);
    exp_ovr = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_idle_busy", 32'(busy), 0);
    chk("t5_idle_valid", 32'(sif.out_valid), 0);
    start_packet(1'b0);
    stream(0, -1);

    // T6: done held high across a whole packet and beyond
    start_packet(1'b1);
    stream(0, -1);
    repeat (10) @(negedge clk);
    chk("t6_no_retrigger_valid", 32'(sif.out_valid), 0);
    chk("t6_no_retrigger_busy", 32'(busy), 0);
    done = 1'b0;
    @(negedge clk);
    start_packet(1'b0);
    stream(0, -1);

    // Random labels (including out-of-range) with random backpressure;
    // inputs are scrambled after capture and must not leak into the packet.
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < FR; i++) lab[i] = 2'($urandom_range(0, 3));
      start_packet(1'b0);
      for (int i = 0; i < FR; i++) lab[i] = 2'($urandom_range(0, 3));
      stream(1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
